uart_value_reporter: RTL and testbench

Formats a channel number and unsigned binary value into an ASCII report line, e.g. "CH3=12345\r\n", and hands it to the UART transmit supervisor as a single string. It sits directly upstream of the supervisor and drives its begin, data and length inputs. It also consumes the supervisor's busy and done status so that only one report is in flight at a time. Binary-to-decimal conversion is sequential (shift-add-3, one bit per clock).

---
 rtl/uart_pkg.sv | 46 ++++
 rtl/uart_value_reporter_bin2bcd.sv | 60 ++++++
 rtl/uart_value_reporter.sv | 134 +++++++++++++
 tb/tb_uart_value_reporter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART value reporter: FSM encodings, ASCII constants,
// the supervisor message payload and small character/BCD helpers.
package uart_pkg;

  localparam int unsigned STATE_W      = 3;
  localparam int unsigned TX_BUF_BYTES = 14;
  localparam int unsigned TX_BUF_W     = TX_BUF_BYTES * 8;
  localparam int unsigned LEN_W        = 8;
  localparam int unsigned BCD_DIGITS   = 5;
  localparam int unsigned BCD_W        = BCD_DIGITS * 4;

  localparam logic [STATE_W-1:0] s_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] s_CONVERT = 3'd1;
  localparam logic [STATE_W-1:0] s_PACK    = 3'd2;
  localparam logic [STATE_W-1:0] s_LAUNCH  = 3'd3;
  localparam logic [STATE_W-1:0] s_WAIT    = 3'd4;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_EQ   = 8'h3D;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  typedef struct packed {
    logic [TX_BUF_W-1:0] data;
    logic [LEN_W-1:0]    len;
  } tx_msg_t;

  // Double-dabble correction: add 3 to every digit that is 5 or more.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? ASCII_ZERO + {4'b0, n} : 8'h37 + {4'b0, n};
  endfunction

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return ASCII_ZERO + {4'b0, d};
  endfunction

endpackage

// File: rtl/uart_value_reporter_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per clock.
module bin2bcd_seq
  import uart_pkg::*;
#(
  parameter int unsigned VALUE_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [VALUE_WIDTH-1:0] value_i,
  output logic [BCD_W-1:0]       bcd_o,
  output logic                   done_c_o
);

  localparam int unsigned CNT_W = 5;

  logic [VALUE_WIDTH-1:0] value_q, value_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d, adj;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   run_q, run_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
    end
  end

  // Asserted during the cycle whose closing edge performs the final shift.
  assign done_c_o = run_q && (cnt_q == CNT_W'(VALUE_WIDTH - 1));

  always_comb begin
    value_d = value_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    adj     = bcd_adjust(bcd_q);
    if (start_i) begin
      value_d = value_i;
      bcd_d   = '0;
      cnt_d   = '0;
      run_d   = 1'b1;
    end else if (run_q) begin
      bcd_d   = {adj[BCD_W-2:0], value_q[VALUE_WIDTH-1]};
      value_d = value_q << 1;
      cnt_d   = cnt_q + CNT_W'(1);
      if (done_c_o) run_d = 1'b0;
    end
  end

  assign bcd_o = bcd_q;

endmodule

// File: rtl/uart_value_reporter.sv
// Formats "<PREFIX><hex ch>=<decimal>\r\n" and launches it on the UART supervisor.
// Optional UART_REPORTER_ZERO_SUPPRESS_EN drops leading zero digits (keeps one).
module uart_value_reporter
  import uart_pkg::*;
#(
  parameter int unsigned VALUE_WIDTH = 16,
  parameter logic [15:0] PREFIX      = 16'h4348
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valueValid,
  input  logic [VALUE_WIDTH-1:0] i_value,
  input  logic [3:0]             i_channel,
  input  logic                   i_txBusy,
  input  logic                   i_txDone,
  output logic                   o_txBegin,
  output logic [TX_BUF_W-1:0]    o_txData,
  output logic [LEN_W-1:0]       o_txDataLength,
  output logic                   o_busy,
  output logic                   o_overrun
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [3:0]         channel_q, channel_d;
  tx_msg_t            msg_q, msg_d, pack_c;
  logic               begin_q, begin_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;
  logic               conv_start_c, conv_done_c;
  logic [BCD_W-1:0]   bcd;

  bin2bcd_seq #(.VALUE_WIDTH(VALUE_WIDTH)) u_bin2bcd (
    .clk_i    (i_clock),
    .rst_i    (i_reset),
    .start_i  (conv_start_c),
    .value_i  (i_value),
    .bcd_o    (bcd),
    .done_c_o (conv_done_c)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= s_IDLE;
      channel_q <= '0;
      msg_q     <= '0;
      begin_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      channel_q <= channel_d;
      msg_q     <= msg_d;
      begin_q   <= begin_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  // Message builder: head sits directly above the kept digits plus CR/LF.
  logic [31:0]         head;
  logic [55:0]         tail;
  logic [TX_BUF_W-1:0] mask;
  int unsigned         ndigits;
  int unsigned         keep;

  always_comb begin
    ndigits = BCD_DIGITS;
`ifdef UART_REPORTER_ZERO_SUPPRESS_EN
    ndigits = 1;
    for (int unsigned i = 1; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) ndigits = i + 1;
    end
`endif
    head = {PREFIX, hex_char(channel_q), ASCII_EQ};
    tail = {40'b0, ASCII_CR, ASCII_LF};
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      tail[16 + 8*i +: 8] = digit_char(bcd[4*i +: 4]);
    end
    keep        = (ndigits + 2) * 8;
    mask        = ~({TX_BUF_W{1'b1}} << keep);
    pack_c.data = (TX_BUF_W'(head) << keep) | (TX_BUF_W'(tail) & mask);
    pack_c.len  = LEN_W'(ndigits + 6);
  end

  always_comb begin
    state_d      = state_q;
    channel_d    = channel_q;
    msg_d        = msg_q;
    begin_d      = 1'b0;
    busy_d       = busy_q;
    overrun_d    = 1'b0;
    conv_start_c = 1'b0;
    case (state_q)
      s_IDLE: begin
        if (i_valueValid) begin
          channel_d    = i_channel;
          busy_d       = 1'b1;
          conv_start_c = 1'b1;
          state_d      = s_CONVERT;
        end
      end
      s_CONVERT: if (conv_done_c) state_d = s_PACK;
      s_PACK: begin
        msg_d   = pack_c;
        state_d = s_LAUNCH;
      end
      s_LAUNCH: begin
        if (!i_txBusy) begin
          begin_d = 1'b1;
          state_d = s_WAIT;
        end
      end
      s_WAIT: begin
        if (i_txDone) begin
          busy_d  = 1'b0;
          state_d = s_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = s_IDLE;
      end
    endcase
    // Requests outside idle are dropped, never queued.
    if (i_valueValid && (state_q != s_IDLE)) overrun_d = 1'b1;
  end

  assign o_txBegin      = begin_q;
  assign o_txData       = msg_q.data;
  assign o_txDataLength = msg_q.len;
  assign o_busy         = busy_q;
  assign o_overrun      = overrun_q;

endmodule

// File: tb/tb_uart_value_reporter.sv
// Self-checking bench for uart_value_reporter with a report scoreboard.
// Honours UART_REPORTER_ZERO_SUPPRESS_EN for the expected text.
module tb_uart_value_reporter;

  localparam int LAT = 18;

  typedef struct packed {
    logic [111:0] data;
    logic [7:0]   len;
  } rep_t;

  logic         i_clock = 1'b0;
  logic         i_reset = 1'b1;
  logic         i_valueValid = 1'b0;
  logic [15:0]  i_value = '0;
  logic [3:0]   i_channel = '0;
  logic         i_txBusy = 1'b0;
  logic         i_txDone = 1'b0;
  logic         o_txBegin;
  logic [111:0] o_txData;
  logic [7:0]   o_txDataLength;
  logic         o_busy;
  logic         o_overrun;

  rep_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  uart_value_reporter dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_valueValid   (i_valueValid),
    .i_value        (i_value),
    .i_channel      (i_channel),
    .i_txBusy       (i_txBusy),
    .i_txDone       (i_txDone),
    .o_txBegin      (o_txBegin),
    .o_txData       (o_txData),
    .o_txDataLength (o_txDataLength),
    .o_busy         (o_busy),
    .o_overrun      (o_overrun)
  );

  always #5 i_clock = ~i_clock;

  // Reference text built with decimal arithmetic, one character at a time.
  function automatic rep_t model(input int unsigned v, input logic [3:0] ch);
    rep_t        r;
    logic [7:0]  b[$];
    int          dig[5];
    int unsigned t;
    int          first;
    t = v;
    for (int i = 0; i < 5; i++) begin
      dig[i] = int'(t % 10);
      t = t / 10;
    end
    first = 4;
`ifdef UART_REPORTER_ZERO_SUPPRESS_EN
    while (first > 0 && dig[first] == 0) first--;
`endif
    b.push_back(8'h43);
    b.push_back(8'h48);
    b.push_back((ch < 4'd10) ? 8'(48 + int'(ch)) : 8'(55 + int'(ch)));
    b.push_back(8'h3D);
    for (int i = first; i >= 0; i--) b.push_back(8'(48 + dig[i]));
    b.push_back(8'h0D);
    b.push_back(8'h0A);
    r.data = '0;
    foreach (b[i]) r.data = {r.data[103:0], b[i]};
    r.len = 8'(b.size());
    return r;
  endfunction

  task automatic send_req(input logic [15:0] v, input logic [3:0] ch, input bit expect_report);
    i_valueValid = 1'b1;
    i_value      = v;
    i_channel    = ch;
    if (expect_report) exp_q.push_back(model(v, ch));
    @(posedge i_clock);
    @(negedge i_clock);
    i_valueValid = 1'b0;
  endtask

  task automatic wait_begin(output int n);
    n = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge i_clock);
      @(negedge i_clock);
      if (o_txBegin === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic pop_exp(output rep_t e);
    e = '0;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected at least 1");
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  task automatic finish_tx();
    i_txDone = 1'b1;
    @(posedge i_clock);
    @(negedge i_clock);
    i_txDone = 1'b0;
  endtask

  task automatic cycle();
    @(posedge i_clock);
    @(negedge i_clock);
  endtask

  task automatic test_reset();
    @(negedge i_clock);
    @(negedge i_clock);
    checks++;
    if ({o_txBegin, o_busy, o_overrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000", {o_txBegin, o_busy, o_overrun});
    end
    checks++;
    if ({o_txData, o_txDataLength} !== 120'd0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h expected 0/0", o_txData, o_txDataLength);
    end
    i_reset = 1'b0;
    @(negedge i_clock);
  endtask

  task automatic test_basic();
    int   n;
    rep_t e;
    send_req(16'd12345, 4'h3, 1'b1);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_rise: got %b expected 1", o_busy);
    end
    wait_begin(n);
    checks++;
    if (n !== LAT) begin
      errors++;
      $display("FAIL basic_begin_edge: got %0d expected %0d", n, LAT);
    end
    pop_exp(e);
    checks++;
    if (o_txData !== e.data) begin
      errors++;
      $display("FAIL basic_data: got %h expected %h", o_txData, e.data);
    end
    checks++;
    if (o_txData !== {24'h0, 88'h4348333D31323334350D0A} || o_txDataLength !== 8'd11) begin
      errors++;
      $display("FAIL basic_literal: got %h len %0d expected 4348333D31323334350D0A len 11",
               o_txData, o_txDataLength);
    end
    cycle();
    checks++;
    if (o_txBegin !== 1'b0) begin
      errors++;
      $display("FAIL basic_begin_fall: got %b expected 0", o_txBegin);
    end
    finish_tx();
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_fall: got %b expected 0", o_busy);
    end
  endtask

  task automatic test_zero_and_max();
    int   n;
    rep_t e;
    logic [7:0] zlen;
`ifdef UART_REPORTER_ZERO_SUPPRESS_EN
    zlen = 8'd7;
`else
    zlen = 8'd11;
`endif
    send_req(16'd0, 4'hA, 1'b1);
    wait_begin(n);
    pop_exp(e);
    checks++;
    if (n !== LAT || o_txData !== e.data) begin
      errors++;
      $display("FAIL zero_report: got edge %0d data %h expected edge %0d data %h", n, o_txData, LAT, e.data);
    end
    checks++;
    if (o_txDataLength !== zlen) begin
      errors++;
      $display("FAIL zero_length: got %0d expected %0d", o_txDataLength, zlen);
    end
    cycle();
    finish_tx();
    send_req(16'hFFFF, 4'hF, 1'b1);
    wait_begin(n);
    pop_exp(e);
    checks++;
    if (n !== LAT || o_txData !== e.data || o_txDataLength !== 8'd11) begin
      errors++;
      $display("FAIL max_report: got edge %0d data %h len %0d expected edge %0d data %h len 11",
               n, o_txData, o_txDataLength, LAT, e.data);
    end
    cycle();
    finish_tx();
  endtask

  task automatic test_overrun();
    int   n;
    int   nbeg;
    rep_t e;
    send_req(16'd777, 4'h1, 1'b1);
    wait_begin(n);
    pop_exp(e);
    checks++;
    if (n !== LAT || o_txData !== e.data) begin
      errors++;
      $display("FAIL ovr_first: got edge %0d data %h expected edge %0d data %h", n, o_txData, LAT, e.data);
    end
    cycle();
    i_valueValid = 1'b1;
    i_value      = 16'd1234;
    cycle();
    i_valueValid = 1'b0;
    checks++;
    if (o_overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_pulse: got %b expected 1", o_overrun);
    end
    cycle();
    checks++;
    if (o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_pulse_width: got %b expected 0", o_overrun);
    end
    nbeg = 0;
    repeat (25) begin
      cycle();
      if (o_txBegin === 1'b1) nbeg++;
    end
    checks++;
    if (nbeg !== 0 || o_busy !== 1'b1 || o_txData !== e.data) begin
      errors++;
      $display("FAIL ovr_no_relaunch: got begins %0d busy %b expected begins 0 busy 1", nbeg, o_busy);
    end
    // Completion and a new request on the same edge: request must be dropped.
    i_txDone     = 1'b1;
    i_valueValid = 1'b1;
    cycle();
    i_txDone     = 1'b0;
    i_valueValid = 1'b0;
    checks++;
    if (o_overrun !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL ovr_same_cycle: got overrun %b busy %b expected 1 0", o_overrun, o_busy);
    end
    nbeg = 0;
    repeat (25) begin
      cycle();
      if (o_txBegin === 1'b1 || o_busy === 1'b1) nbeg++;
    end
    checks++;
    if (nbeg !== 0) begin
      errors++;
      $display("FAIL ovr_same_cycle_dropped: got %0d active cycles expected 0", nbeg);
    end
    send_req(16'd500, 4'h2, 1'b1);
    wait_begin(n);
    pop_exp(e);
    checks++;
    if (n !== LAT || o_txData !== e.data || o_txDataLength !== e.len) begin
      errors++;
      $display("FAIL ovr_recover: got edge %0d data %h expected edge %0d data %h", n, o_txData, LAT, e.data);
    end
    cycle();
    finish_tx();
  endtask

  task automatic test_busy_holdoff();
    int   nbeg;
    rep_t e;
    i_txBusy = 1'b1;
    send_req(16'd3141, 4'hC, 1'b1);
    nbeg = 0;
    for (int k = 1; k <= 22; k++) begin
      cycle();
      if (o_txBegin === 1'b1) nbeg++;
      if (k == 17) begin
        checks++;
        if (exp_q.size() == 0 || o_txData !== exp_q[0].data) begin
          errors++;
          $display("FAIL hold_data_early: got %h at edge 17 expected report text", o_txData);
        end
      end
    end
    i_txBusy = 1'b0;
    cycle();
    checks++;
    if (nbeg !== 0 || o_txBegin !== 1'b1) begin
      errors++;
      $display("FAIL hold_deferred: got early begins %0d begin %b expected 0 1", nbeg, o_txBegin);
    end
    pop_exp(e);
    checks++;
    if (o_txData !== e.data || o_txDataLength !== e.len) begin
      errors++;
      $display("FAIL hold_data: got %h len %0d expected %h len %0d", o_txData, o_txDataLength, e.data, e.len);
    end
    cycle();
    checks++;
    if (o_txBegin !== 1'b0) begin
      errors++;
      $display("FAIL hold_begin_width: got %b expected 0", o_txBegin);
    end
    finish_tx();
  endtask

  task automatic test_reset_mid();
    int   n;
    int   nact;
    rep_t e;
    send_req(16'd9999, 4'h5, 1'b0);
    repeat (7) cycle();
    @(posedge i_clock);
    i_reset = 1'b1;
    #1;
    checks++;
    if ({o_txBegin, o_busy, o_overrun, o_txDataLength} !== 11'd0 || o_txData !== 112'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got begin %b busy %b ovr %b len %0d data %h expected all 0",
               o_txBegin, o_busy, o_overrun, o_txDataLength, o_txData);
    end
    @(negedge i_clock);
    i_reset = 1'b0;
    finish_tx();
    nact = 0;
    repeat (25) begin
      cycle();
      if (o_txBegin === 1'b1 || o_busy === 1'b1 || o_overrun === 1'b1) nact++;
    end
    checks++;
    if (nact !== 0) begin
      errors++;
      $display("FAIL rst_mid_idle: got %0d active cycles expected 0", nact);
    end
    send_req(16'd42, 4'h7, 1'b1);
    wait_begin(n);
    pop_exp(e);
    checks++;
    if (n !== LAT || o_txData !== e.data || o_txDataLength !== e.len) begin
      errors++;
      $display("FAIL rst_mid_next: got edge %0d data %h len %0d expected edge %0d data %h len %0d",
               n, o_txData, o_txDataLength, LAT, e.data, e.len);
    end
    cycle();
    finish_tx();
  endtask

  task automatic test_back_to_back();
    int          n;
    rep_t        e;
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      v = (i == 0) ? 16'd100 : 16'($urandom_range(0, 65535));
      send_req(v, 4'($urandom_range(0, 15)), 1'b1);
      wait_begin(n);
      pop_exp(e);
      checks++;
      if (n !== LAT || o_txData !== e.data || o_txDataLength !== e.len) begin
        errors++;
        $display("FAIL b2b_%0d value %0d: got edge %0d data %h len %0d expected edge %0d data %h len %0d",
                 i, v, n, o_txData, o_txDataLength, LAT, e.data, e.len);
      end
      cycle();
      finish_tx();
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_and_max();
    test_overrun();
    test_busy_holdoff();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
